// File: rtl/mmio_pkg.sv
// Shared encodings and defaults for the CPU-to-RAM/board-I/O memory-mapped bridge.
package mmio_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_ILL   = 2'b11
  } mem_cmd_e;

  localparam logic [8:0] DEF_OUT_BASE = 9'h100;
  localparam logic [8:0] DEF_IN_BASE  = 9'h140;
  localparam logic [8:0] DEF_TMR_BASE = 9'h1C0;

  localparam int TMR_EN_BIT  = 0;
  localparam int TMR_CLR_BIT = 1;
  localparam int TMR_OVF_BIT = 15;

endpackage

// File: rtl/mmio_if.sv
// CPU-side memory bus: command, address, write payload and registered read result.
interface mmio_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (output mem_cmd, output mem_addr, output write_data, input read_data);
  modport slave  (input mem_cmd, input mem_addr, input write_data, output read_data);
endinterface

// File: rtl/mmio_sync2.sv
// Two-flop synchroniser for an asynchronous input word, cleared by the async reset.
module mmio_sync2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] async_in,
  output logic [DATA_W-1:0] sync_out
);

  logic [DATA_W-1:0] meta_r;
  logic [DATA_W-1:0] sync_r;

  // metastability stage followed by the stable output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/mmio_bridge.sv
// Memory-mapped bridge: lower half of the address space goes to RAM, upper half
// holds output registers, synchronised input ports and a free-running cycle timer.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int               DATA_W   = 16,
  parameter int               ADDR_W   = 9,
  parameter int               NUM_OUT  = 2,
  parameter int               NUM_IN   = 2,
  parameter logic [ADDR_W-1:0] OUT_BASE = DEF_OUT_BASE,
  parameter logic [ADDR_W-1:0] IN_BASE  = DEF_IN_BASE,
  parameter logic [ADDR_W-1:0] TMR_BASE = DEF_TMR_BASE
) (
  input  logic                      clk,
  input  logic                      reset,
  mmio_if.slave                     bus,
  output logic [ADDR_W-2:0]         ram_addr,
  output logic                      ram_write,
  output logic [DATA_W-1:0]         ram_din,
  input  logic [DATA_W-1:0]         ram_dout,
  input  logic [NUM_IN*DATA_W-1:0]  in_port,
  output logic [NUM_OUT*DATA_W-1:0] out_port,
  output logic                      bus_err
);

  if ((NUM_OUT < 1) || (NUM_OUT > 64) || (NUM_IN < 1) || (NUM_IN > 64) || (DATA_W < 16) ||
      !OUT_BASE[ADDR_W-1] || !IN_BASE[ADDR_W-1] || !TMR_BASE[ADDR_W-1] ||
      (int'(OUT_BASE) + NUM_OUT > int'(IN_BASE)) ||
      (int'(IN_BASE) + NUM_IN > int'(TMR_BASE)) ||
      (int'(TMR_BASE) + 2 > (1 << ADDR_W))) begin : g_bad_cfg
    $error("mmio_bridge: address regions overlap or exceed the I/O half");
  end

  logic [ADDR_W-1:0]  addr_s;
  logic [DATA_W-1:0]  wdata_s;
  logic               is_io_s, rd_s, wr_s, ill_s;
  logic [NUM_OUT-1:0] out_sel_s;
  logic [NUM_IN-1:0]  in_sel_s;
  logic               cnt_hit_s, ctl_hit_s, unmapped_s;
  logic [DATA_W-1:0]  in_sync_s [NUM_IN];
  logic [DATA_W-1:0]  out_reg_r [NUM_OUT];
  logic [DATA_W-1:0]  count_r, count_nxt_s, ctl_rd_s, io_rd_s;
  logic               en_r, ovf_r, ovf_nxt_s;
  logic               ctl_wr_s, clr_s, w1c_s, preload_s, wrap_s;
  logic [DATA_W-1:0]  io_data_r, read_data_r;
  logic               rd_pend_r, rd_ram_r, bus_err_r;

  assign addr_s  = bus.mem_addr;
  assign wdata_s = bus.write_data;

  // command and address decode
  always_comb begin
    is_io_s = addr_s[ADDR_W-1];
    rd_s    = (bus.mem_cmd == MEM_READ);
    wr_s    = (bus.mem_cmd == MEM_WRITE);
    ill_s   = (bus.mem_cmd == MEM_ILL);
    for (int i = 0; i < NUM_OUT; i++) begin
      out_sel_s[i] = (addr_s == OUT_BASE + ADDR_W'(i));
    end
    for (int i = 0; i < NUM_IN; i++) begin
      in_sel_s[i] = (addr_s == IN_BASE + ADDR_W'(i));
    end
    cnt_hit_s  = (addr_s == TMR_BASE);
    ctl_hit_s  = (addr_s == TMR_BASE + ADDR_W'(1));
    unmapped_s = is_io_s && !((|out_sel_s) || (|in_sel_s) || cnt_hit_s || ctl_hit_s);
  end

  assign ram_addr  = addr_s[ADDR_W-2:0];
  assign ram_din   = wdata_s;
  assign ram_write = wr_s & ~is_io_s;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_sync
    mmio_sync2 #(.DATA_W(DATA_W)) u_sync (
      .clk      (clk),
      .rst_n    (reset),
      .async_in (in_port[g*DATA_W +: DATA_W]),
      .sync_out (in_sync_s[g])
    );
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_port[g*DATA_W +: DATA_W] = out_reg_r[g];
  end

  // I/O read mux; selects are one-hot so OR-combining is exact, unmapped gives 0
  always_comb begin
    ctl_rd_s              = '0;
    ctl_rd_s[TMR_EN_BIT]  = en_r;
    ctl_rd_s[TMR_OVF_BIT] = ovf_r;
    io_rd_s = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      io_rd_s = io_rd_s | (out_sel_s[i] ? out_reg_r[i] : '0);
    end
    for (int i = 0; i < NUM_IN; i++) begin
      io_rd_s = io_rd_s | (in_sel_s[i] ? in_sync_s[i] : '0);
    end
    io_rd_s = io_rd_s | (cnt_hit_s ? count_r : '0) | (ctl_hit_s ? ctl_rd_s : '0);
  end

  // timer next state: CLR beats preload beats increment; a wrap beats OVF W1C
  always_comb begin
    ctl_wr_s  = wr_s & ctl_hit_s;
    clr_s     = ctl_wr_s & wdata_s[TMR_CLR_BIT];
    w1c_s     = ctl_wr_s & wdata_s[TMR_OVF_BIT];
    preload_s = wr_s & cnt_hit_s;
    wrap_s    = en_r & ~clr_s & ~preload_s & (&count_r);
    if (clr_s) begin
      count_nxt_s = '0;
    end else if (preload_s) begin
      count_nxt_s = wdata_s;
    end else if (en_r) begin
      count_nxt_s = count_r + DATA_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
    if (wrap_s) begin
      ovf_nxt_s = 1'b1;
    end else if (w1c_s) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // output register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUT; i++) out_reg_r[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (wr_s && out_sel_s[i]) out_reg_r[i] <= wdata_s;
      end
    end
  end

  // timer count and control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
      en_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      if (ctl_wr_s) en_r <= wdata_s[TMR_EN_BIT];
    end
  end

  // two-stage read pipeline: capture source at the read edge, publish one edge later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_r   <= 1'b0;
      rd_ram_r    <= 1'b0;
      io_data_r   <= '0;
      read_data_r <= '0;
    end else begin
      rd_pend_r <= rd_s;
      if (rd_s) begin
        rd_ram_r  <= ~is_io_s;
        io_data_r <= io_rd_s;
      end
      if (rd_pend_r) read_data_r <= rd_ram_r ? ram_dout : io_data_r;
    end
  end

  // sticky illegal-access flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_err_r <= 1'b0;
    end else if (ill_s || ((rd_s || wr_s) && unmapped_s)) begin
      bus_err_r <= 1'b1;
    end
  end

  assign bus.read_data = read_data_r;
  assign bus_err       = bus_err_r;

endmodule
